// File: rtl/not5_share_scheduler_pkg.sv
// Shared types and constants for the shared-inverter scheduler.
// State encoding, counter and requester-index widths live here.
package not5_share_scheduler_pkg;

    localparam int CNT_W = 4;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter load value for a given hold latency.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat);
    endfunction

endpackage

// File: rtl/not5_share_scheduler_rr_picker.sv
// Round-robin picker: first set request after the last winner.
// Purely combinational; returns both one-hot and index forms.
module rr_picker
    import not5_share_scheduler_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] idx
);

    logic found;
    int   cand;

    // Walk last+1, last+2, ... (mod N) and keep the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && ((req >> cand) & N'(1)) != '0) begin
                found  = 1'b1;
                onehot = N'(1) << cand;
                idx    = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/not5bit.sv
// Bitwise inverter unit shared by all requesters.
// Purely combinational: res is the complement of data_in.
module not5bit #(
    parameter int W = 5
) (
    input  logic [W-1:0] data_in,
    output logic [W-1:0] res
);

    assign res = ~data_in;

endmodule

// File: rtl/not5_share_scheduler.sv
// Shares one not5bit inverter among N round-robin requesters.
// Operand is held LAT cycles at the unit; result returned with id.
module not5_share_scheduler
    import not5_share_scheduler_pkg::*;
#(
    parameter int N   = 2,
    parameter int W   = 5,
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data_in,
    output logic [N-1:0]    gnt,
    output logic [W-1:0]    res,
    output logic            res_valid,
    output logic [ID_W-1:0] res_id,
    output logic            busy
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     opnd;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  last;
    logic [N-1:0]     pick_oh;
    logic [ID_W-1:0]  pick_idx;
    logic [W-1:0]     unit_res;
    logic             take;
    logic             finish;

    rr_picker #(.N(N)) u_picker (
        .req    (req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // The latched operand feeds the unit for the whole BUSY window.
    not5bit #(.W(W)) u_not5 (
        .data_in (opnd),
        .res     (unit_res)
    );

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus accept/finish strobes; arbitration only in IDLE.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        finish  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req != '0) begin
                    take    = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 4'd1) begin
                    finish  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Operand latch, hold counter, result/grant registers, RR pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            opnd      <= '0;
            id        <= '0;
            cnt       <= '0;
            last      <= ID_W'(N - 1);
        end else begin
            gnt       <= take ? pick_oh : '0;
            res_valid <= finish;
            if (take) begin
                opnd <= W'(data_in >> (int'(pick_idx) * W));
                id   <= pick_idx;
                cnt  <= lat_load(LAT);
            end else if (state == S_BUSY && !finish) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                res    <= unit_res;
                res_id <= id;
            end
            if (state == S_DONE) begin
                last <= id;
            end
        end
    end

endmodule

// File: tb/tb_not5_share_scheduler.sv
// Scoreboard bench for not5_share_scheduler (N=2, LAT=1 and LAT=3).
// Transaction-level model predicts grants/results; monitor compares.
module tb_not5_share_scheduler;

    localparam int N    = 2;
    localparam int W    = 5;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    typedef struct {
        int id;
        int cyc;
    } g_t;

    typedef struct {
        int         id;
        logic [W-1:0] val;
        int         cyc;
    } r_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   res;
    logic           rv;
    logic [2:0]     rid;
    logic           busy;

    logic [N-1:0]   req3;
    logic [N*W-1:0] data3;
    logic [N-1:0]   gnt3;
    logic [W-1:0]   res3;
    logic           rv3;
    logic [2:0]     rid3;
    logic           busy3;

    int   nchecks = 0;
    int   nerr    = 0;
    int   cyc     = 0;
    int   busy_left;
    int   last_m;
    logic exp_busy = 1'b0;
    logic [N-1:0] clr;
    logic [W-1:0] res_hold;
    g_t   gq[$];
    r_t   rq[$];

    not5_share_scheduler #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data),
        .gnt       (gnt),
        .res       (res),
        .res_valid (rv),
        .res_id    (rid),
        .busy      (busy)
    );

    not5_share_scheduler #(.N(N), .W(W), .LAT(LAT3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req       (req3),
        .data_in   (data3),
        .gnt       (gnt3),
        .res       (res3),
        .res_valid (rv3),
        .res_id    (rid3),
        .busy      (busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference: one transaction per LAT+2 cycles, RR order, ~operand.
    task automatic model_step();
        int w;
        clr = '0;
        w   = -1;
        if (rst) begin
            busy_left = 0;
            last_m    = N - 1;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last_m + k) % N;
                if (w < 0 && req[i]) w = i;
            end
            gq.push_back('{id: w, cyc: cyc});
            rq.push_back('{id: w, val: ~data[w*W +: W], cyc: cyc + LAT});
            clr[w]    = 1'b1;
            last_m    = w;
            busy_left = LAT + 1;
        end
        exp_busy = (busy_left > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        req = req & ~clr;
    endtask

    task automatic model_reset();
        gq.delete();
        rq.delete();
        busy_left = 0;
        last_m    = N - 1;
        exp_busy  = 1'b0;
    endtask

    // Monitor: pops expected grants/results whenever the DUT shows one.
    always @(negedge clk) begin
        if (rst) begin
            res_hold = '0;
            chk("reset_outs", {gnt, rv, busy, res}, '0);
        end else begin
            chk("gnt_rv_overlap", 32'(gnt != '0 && rv), 0);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 0);
                end else begin
                    g_t e;
                    e = gq.pop_front();
                    chk("gnt_onehot", 32'(gnt), 32'(1) << e.id);
                    chk("gnt_cycle", cyc, e.cyc);
                end
            end else if (gq.size() > 0 && gq[0].cyc < cyc) begin
                g_t e;
                e = gq.pop_front();
                chk("gnt_missing", 0, 32'(1) << e.id);
            end
            if (rv) begin
                if (rq.size() == 0) begin
                    chk("res_unexpected", 32'(rv), 0);
                end else begin
                    r_t e;
                    e = rq.pop_front();
                    chk("res_val", 32'(res), 32'(e.val));
                    chk("res_id", 32'(rid), e.id);
                    chk("res_cycle", cyc, e.cyc);
                    res_hold = e.val;
                end
            end else begin
                if (rq.size() > 0 && rq[0].cyc < cyc) begin
                    r_t e;
                    e = rq.pop_front();
                    chk("res_missing", 0, 32'(e.val));
                end
                chk("res_hold", 32'(res), 32'(res_hold));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gt, vt, bc;
        logic [N-1:0] g3v;
        logic [W-1:0] r3v;
        logic [2:0]   i3v;

        rst   = 1'b1;
        req   = 2'b11;
        data  = '0;
        req3  = '0;
        data3 = '0;
        model_reset();

        // Reset held three cycles with requests pending.
        repeat (3) tick();
        req = '0;
        #2 rst = 1'b0;
        @(negedge clk);

        // LAT=3 instance: latency and busy length.
        req3  = 2'b10;
        data3 = {5'b01010, 5'b00000};
        gt = -1; vt = -1; bc = 0;
        g3v = '0; r3v = '0; i3v = '0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (gnt3 != '0) begin
                gt   = t;
                g3v  = gnt3;
                req3 = '0;
            end
            if (rv3) begin
                vt  = t;
                r3v = res3;
                i3v = rid3;
            end
            if (busy3) bc++;
        end
        chk("lat3_gnt", 32'(g3v), 32'(2'b10));
        chk("lat3_gnt_seen", 32'(gt >= 0), 1);
        chk("lat3_latency", vt - gt, LAT3);
        chk("lat3_res", 32'(r3v), 32'(5'b10101));
        chk("lat3_id", 32'(i3v), 1);
        chk("lat3_busy_cycles", bc, LAT3 + 1);

        // Single op.
        req  = 2'b01;
        data = {5'b00000, 5'b10101};
        repeat (4) tick();

        // Round-robin under continuous requests.
        data = {5'b00000, 5'b11111};
        req  = 2'b11;
        repeat (3) begin
            tick();
            req = 2'b11;
            repeat (LAT + 1) tick();
        end
        req = '0;
        repeat (4) tick();

        // Late request from r1 while r0 is busy.
        data = {5'b01100, 5'b00011};
        req  = 2'b01;
        tick();
        req = req | 2'b10;
        repeat (6) tick();

        // Abort mid-transaction, then r0 wins first again.
        req  = 2'b10;
        tick();
        req  = 2'b01;
        repeat (LAT + 1) tick();
        tick();
        #2 rst = 1'b1;
        model_reset();
        req = 2'b11;
        repeat (2) tick();
        #2 rst = 1'b0;
        repeat (8) tick();
        req = '0;
        repeat (4) tick();

        // Randomized traffic with occasional request withdrawal.
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req[i]          = 1'b1;
                        data[i*W +: W]  = W'($urandom);
                    end
                end else if ($urandom_range(15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end

        req = '0;
        repeat (LAT + 6) tick();
        chk("gnt_queue_drained", gq.size(), 0);
        chk("res_queue_drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
